fft_peak_detect: RTL and testbench

- Downstream of the FFT control stage. Consumes the streamed 512-bin complex FFT output and computes the squared magnitude of each bin.
- Tracks the bin with the largest magnitude inside a configurable search window.
- Reports peak bin index and magnitude to the tuner pitch logic, or to the SPI result buffer, once per frame.
- Pipelined to accept one sample per clock.

---
 rtl/fft_peak_detect.sv | 185 ++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: streams one 512-bin complex FFT frame, squares each bin
// and reports the largest-magnitude bin inside [MIN_BIN, MAX_BIN].
// Optional macro FFT_PEAK_NEIGHBOR_EN adds left_mag/right_mag outputs
// holding the magnitudes of the bins adjacent to the peak.
module fft_peak_detect #(
  parameter int N          = 512,
  parameter int DATA_W     = 16,
  parameter int MIN_BIN    = 2,
  parameter int MAX_BIN    = 255,
  parameter int MAG_THRESH = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [2*DATA_W-1:0]      in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     result_valid,
  output logic [$clog2(N)-1:0]     peak_bin,
  output logic [2*DATA_W-1:0]      peak_mag,
  output logic                     peak_found
`ifdef FFT_PEAK_NEIGHBOR_EN
  ,
  output logic [2*DATA_W-1:0]      left_mag,
  output logic [2*DATA_W-1:0]      right_mag
`endif
);

  localparam int BIN_W = $clog2(N);
  localparam int MAG_W = 2*DATA_W;
  localparam int SQ_W  = 2*DATA_W-1;
  localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] LAST_B   = BIN_W'(N-1);
  localparam logic [BIN_W-1:0] WIN_SPAN = BIN_W'(MAX_BIN-MIN_BIN);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, next_state;

  logic [BIN_W-1:0]  bin_cnt;
  logic              s1_valid, s2_valid;
  logic [SQ_W-1:0]   s1_re_sq, s1_im_sq;
  logic [BIN_W-1:0]  s1_bin, s2_bin;
  logic [MAG_W-1:0]  s2_mag;
  logic              have_cand;

  logic signed [DATA_W-1:0] in_re, in_im;
  logic signed [MAG_W-1:0]  re_ext, im_ext, re_sq_full, im_sq_full;
  logic accept, last_accept, pipe_empty, in_win, peak_upd;

  assign in_re      = in_data[2*DATA_W-1:DATA_W];
  assign in_im      = in_data[DATA_W-1:0];
  assign re_ext     = MAG_W'(in_re);
  assign im_ext     = MAG_W'(in_im);
  assign re_sq_full = re_ext * re_ext;
  assign im_sq_full = im_ext * im_ext;

  // start wins over a coincident sample
  assign accept      = in_valid && (state == ACCUM) && !start;
  assign last_accept = accept && (bin_cnt == LAST_B);
  assign pipe_empty  = !s1_valid && !s2_valid;
  // offset compare keeps the window test free of constant-bound comparisons
  assign in_win      = (BIN_W'(s2_bin - MIN_B) <= WIN_SPAN);
  assign peak_upd    = s2_valid && in_win && (!have_cand || (s2_mag > peak_mag));
  assign peak_found  = (peak_mag > MAG_W'(MAG_THRESH));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last_accept) next_state = DRAIN;
        DRAIN:   if (pipe_empty)  next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == ACCUM);
    busy     = (state == ACCUM) || (state == DRAIN);
  end

  // Bin counter and S1: register squared components with their bin index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s1_bin   <= '0;
    end else if (start) begin
      bin_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        bin_cnt  <= bin_cnt + 1'b1;
        s1_re_sq <= re_sq_full[SQ_W-1:0];
        s1_im_sq <= im_sq_full[SQ_W-1:0];
        s1_bin   <= bin_cnt;
      end
    end
  end

  // S2: sum of squares
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_bin   <= '0;
    end else if (start) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag <= MAG_W'(s1_re_sq) + MAG_W'(s1_im_sq);
        s2_bin <= s1_bin;
      end
    end
  end

  // S3: windowed running maximum, first in-window bin always loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_mag  <= '0;
      peak_bin  <= '0;
      have_cand <= 1'b0;
    end else if (start) begin
      peak_mag  <= '0;
      peak_bin  <= '0;
      have_cand <= 1'b0;
    end else if (peak_upd) begin
      peak_mag  <= s2_mag;
      peak_bin  <= s2_bin;
      have_cand <= 1'b1;
    end
  end

  // Result pulse once the drain empties the pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_valid <= 1'b0;
    else        result_valid <= (state == DRAIN) && pipe_empty && !start;
  end

`ifdef FFT_PEAK_NEIGHBOR_EN
  logic [MAG_W-1:0] prev_mag;
  logic             right_pend;

  // Neighbour capture; prev_mag is cleared per frame so a bin-0 peak sees 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_mag   <= '0;
      left_mag   <= '0;
      right_mag  <= '0;
      right_pend <= 1'b0;
    end else if (start) begin
      prev_mag   <= '0;
      left_mag   <= '0;
      right_mag  <= '0;
      right_pend <= 1'b0;
    end else if (s2_valid) begin
      prev_mag <= s2_mag;
      if (peak_upd) begin
        left_mag   <= prev_mag;
        right_mag  <= '0;
        right_pend <= 1'b1;
      end else if (right_pend) begin
        right_mag  <= s2_mag;
        right_pend <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: frame-level reference model, per-cycle
// compare process and directed frames with literal expectations.
module tb_fft_peak_detect;
  localparam int N = 512, DW = 16, MIN_BIN = 2, MAX_BIN = 255, TH = 0;

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic [2*DW-1:0] in_data;
  logic in_ready, busy, result_valid, peak_found;
  logic [$clog2(N)-1:0] peak_bin;
  logic [2*DW-1:0] peak_mag;
`ifdef FFT_PEAK_NEIGHBOR_EN
  logic [2*DW-1:0] left_mag, right_mag;
`endif

  fft_peak_detect #(.N(N), .DATA_W(DW), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN),
                    .MAG_THRESH(TH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .result_valid(result_valid), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_found(peak_found)
`ifdef FFT_PEAK_NEIGHBOR_EN
    , .left_mag(left_mag), .right_mag(right_mag)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int phase = 0;       // 0 idle/done, 1 feeding, 2 awaiting result
  int last_edge = 0;
  int rv_count = 0;

  int fre[N], fim[N];
  int exp_bin;
  longint exp_mag, exp_left, exp_right, exp_found;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint mag_of(input int b);
    return longint'(fre[b]) * fre[b] + longint'(fim[b]) * fim[b];
  endfunction

  // Reference: argmax over the window, earliest bin wins ties
  task automatic model();
    longint best = -1;
    int bb = MIN_BIN;
    for (int b = MIN_BIN; b <= MAX_BIN; b++)
      if (mag_of(b) > best) begin best = mag_of(b); bb = b; end
    exp_bin   = bb;
    exp_mag   = best;
    exp_found = (best > TH) ? 1 : 0;
    exp_left  = (bb > 0) ? mag_of(bb - 1) : 0;
    exp_right = (bb < N - 1) ? mag_of(bb + 1) : 0;
  endtask

  task automatic clear_frame(input int re, input int im);
    for (int i = 0; i < N; i++) begin fre[i] = re; fim[i] = im; end
  endtask

  task automatic random_frame(input int range);
    for (int i = 0; i < N; i++) begin
      fre[i] = int'($urandom_range(2*range)) - range;
      fim[i] = int'($urandom_range(2*range)) - range;
    end
  endtask

  // Per-cycle compare against the model's expectations
  initial begin
    bit holding = 0;
    int h_bin;
    longint h_mag, h_found;
    forever begin
      @(negedge clk);
      if (!reset) begin
        holding = 0;
      end else begin
        if (result_valid) begin
          rv_count++;
          check("rv_when_expected", phase, 2);
          check("rv_latency", cyc, last_edge + 3);
          check("peak_bin", peak_bin, exp_bin);
          check("peak_mag", peak_mag, exp_mag);
          check("peak_found", peak_found, exp_found);
          check("busy_at_rv", busy, 0);
`ifdef FFT_PEAK_NEIGHBOR_EN
          check("left_mag", left_mag, exp_left);
          check("right_mag", right_mag, exp_right);
`endif
          holding = 1; h_bin = exp_bin; h_mag = exp_mag; h_found = exp_found;
        end else if (holding) begin
          check("hold_bin", peak_bin, h_bin);
          check("hold_mag", peak_mag, h_mag);
          check("hold_found", peak_found, h_found);
          check("done_ready", in_ready, 0);
          check("done_busy", busy, 0);
        end else if (phase == 1) begin
          check("accum_ready", in_ready, 1);
          check("accum_busy", busy, 1);
        end else if (phase == 2) begin
          check("drain_busy", busy, 1);
          check("drain_ready", in_ready, 0);
        end
        if (start) holding = 0;
      end
    end
  end

  // All driver tasks are entered 1 time unit after a rising edge
  task automatic do_start();
    start = 1; in_valid = 0;
    @(posedge clk); #1;
    start = 0;
    check("start_clr_mag", peak_mag, 0);
    check("start_clr_bin", peak_bin, 0);
    check("start_clr_rv", result_valid, 0);
    phase = 1;
  endtask

  task automatic feed(input int count, input int gap_pct);
    for (int i = 0; i < count; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 0; in_data = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1;
      in_data = {16'(fre[i]), 16'(fim[i])};
      @(posedge clk); #1;
      last_edge = cyc;
      in_valid = 0;
    end
  endtask

  task automatic finish_frame();
    int rv0 = rv_count;
    phase = 2;
    for (int k = 0; k < 10 && rv_count == rv0; k++) begin
      @(posedge clk); #1;
    end
    check("rv_arrived", rv_count, rv0 + 1);
    phase = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("rv_single_pulse", rv_count, rv0 + 1);
  endtask

  task automatic run_frame(input int gap_pct);
    model();
    do_start();
    feed(N, gap_pct);
    finish_frame();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv_before;
    reset = 0; start = 0; in_valid = 0; in_data = '0;
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_bin", peak_bin, 0);
    check("rst_mag", peak_mag, 0);
    check("rst_found", peak_found, 0);
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1;

    // 1: reset mid-frame, then an all-zero frame
    random_frame(1000);
    do_start();
    feed(100, 0);
    phase = 0;
    #2 reset = 0;
    #1;
    check("midrst_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mag", peak_mag, 0);
    check("midrst_bin", peak_bin, 0);
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1;
    clear_frame(0, 0);
    run_frame(0);
    check("t1_bin", peak_bin, 2);
    check("t1_mag", peak_mag, 0);
    check("t1_found", peak_found, 0);

    // 2: single dominant bin
    clear_frame(1, 1);
    fre[40] = 1000; fim[40] = -1000;
    run_frame(0);
    check("t2_bin", peak_bin, 40);
    check("t2_mag", peak_mag, 2000000);
    check("t2_found", peak_found, 1);

    // 3: tie, lowest bin wins
    clear_frame(0, 0);
    fre[10] = 300; fim[10] = 400; fre[30] = 300; fim[30] = 400;
    run_frame(10);
    check("t3_bin", peak_bin, 10);
    check("t3_mag", peak_mag, 250000);

    // 4: out-of-window bins ignored
    clear_frame(0, 0);
    fre[0] = 32767; fre[300] = -32768; fim[300] = -32768; fre[100] = 5;
    run_frame(0);
    check("t4_bin", peak_bin, 100);
    check("t4_mag", peak_mag, 25);

    // 5: gappy stream, restart after 200 samples, then a clean frame
    random_frame(20000);
    do_start();
    feed(200, 50);
    clear_frame(0, 0);
    fre[77] = -32768; fim[77] = -32768;
    model();
    do_start();
    feed(N, 50);
    finish_frame();
    check("t5_bin", peak_bin, 77);
    check("t5_mag", peak_mag, 64'd2147483648);
    rv_before = rv_count;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("t5_done_ignores", rv_count, rv_before);
    check("t5_done_mag", peak_mag, 64'd2147483648);

    // 6: neighbour magnitudes around a peak
    clear_frame(0, 0);
    fre[49] = 3; fre[50] = 10; fre[51] = 4;
    run_frame(20);
    check("t6_bin", peak_bin, 50);
    check("t6_mag", peak_mag, 100);
`ifdef FFT_PEAK_NEIGHBOR_EN
    check("t6_left", left_mag, 9);
    check("t6_right", right_mag, 16);
`endif

    // randomized frames: full range, tie-heavy small range, sparse
    for (int f = 0; f < 4; f++) begin
      random_frame(f == 1 ? 2 : 32768 >> (f * 4));
      if (f == 1) begin fre[0] = 0; end
      run_frame(int'($urandom_range(40)));
    end
    begin
      clear_frame(0, 0);
      for (int k = 0; k < 6; k++) begin
        int b = int'($urandom_range(N - 1));
        fre[b] = int'($urandom_range(65535)) - 32768;
        fim[b] = int'($urandom_range(65535)) - 32768;
      end
      fre[MAX_BIN] = 32767; fim[MAX_BIN] = 32767;
      run_frame(25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
